// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared types and constants for the Huffman bit packing path
package huffman_pkg;

  localparam int OUT_W       = 32;
  localparam int PACK_BYTE_W = 8;

  typedef struct packed {
    logic [OUT_W-1:0]   data;
    logic [OUT_W/8-1:0] keep;
    logic               last;
  } packWord_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    LAST  = 2'd2
  } pack_state_t;

endpackage

// File: rtl/huffman_word_assembler.sv
// rtl/huffman_word_assembler.sv - byte stream to word lanes, 0xFF stuffing, output register
// HUFF_PACK_STUFF_EN enables 0xFF -> 0xFF,0x00 insertion.
module huffman_word_assembler
  import huffman_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PACK_BYTE_W-1:0] byte_tdata,
  input  logic                   byte_tvalid,
  output logic                   byte_tready,
  input  logic                   src_idle,
  input  logic                   fin,
  output logic                   fin_done,
  output logic                   stuff_busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [OUT_W/8-1:0]     out_keep,
  output logic                   out_last
);

  localparam int NLANES = OUT_W / PACK_BYTE_W;
  localparam int LANE_W = $clog2(NLANES + 1);

  logic [OUT_W-1:0]       wdata, wdata_nxt;
  logic [LANE_W-1:0]      lanes, lanes_nxt;
  logic                   stuff_pend;
  logic                   full, out_free, xfer, fin_go, space, byte_fire, lane_we;
  logic [PACK_BYTE_W-1:0] lane_byte;
  logic [NLANES-1:0]      keep_mask;

  // A full word is held back once the source has nothing left, so the flush can tag it last.
  assign full        = (lanes == LANE_W'(NLANES));
  assign out_free    = !out_valid || out_ready;
  assign xfer        = full && out_free && !(src_idle && !stuff_pend);
  assign fin_go      = fin && out_free;
  assign space       = !full || xfer;
  assign byte_tready = space && !stuff_pend && !fin;
  assign byte_fire   = byte_tvalid && byte_tready;
  assign lane_we     = byte_fire || (stuff_pend && space);
  assign lane_byte   = stuff_pend ? '0 : byte_tdata;
  assign fin_done    = fin_go;
  assign stuff_busy  = stuff_pend;
  assign keep_mask   = ~({NLANES{1'b1}} >> lanes);

`ifdef HUFF_PACK_STUFF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stuff_pend <= 1'b0;
    end else if (byte_fire && byte_tdata == 8'hFF) begin
      stuff_pend <= 1'b1;
    end else if (stuff_pend && space) begin
      stuff_pend <= 1'b0;
    end
  end
`else
  assign stuff_pend = 1'b0;
`endif

  always_comb begin
    wdata_nxt = (xfer || fin_go) ? '0 : wdata;
    lanes_nxt = (xfer || fin_go) ? '0 : lanes;
    if (lane_we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (lanes_nxt == LANE_W'(i)) begin
          wdata_nxt[OUT_W-1-PACK_BYTE_W*i -: PACK_BYTE_W] = lane_byte;
        end
      end
      lanes_nxt = lanes_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdata     <= '0;
      lanes     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      wdata <= wdata_nxt;
      lanes <= lanes_nxt;
      if (xfer || fin_go) begin
        out_valid <= 1'b1;
        out_data  <= wdata;
        out_keep  <= fin_go ? keep_mask : '1;
        out_last  <= fin_go;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// rtl/huffman_bit_packer.sv - bit accumulator and flush FSM packing Huffman codes MSB-first
// HUFF_PACK_STUFF_EN (in huffman_word_assembler) enables JPEG 0xFF byte stuffing.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int CODE_W = 36,
  parameter int SIZE_W = $clog2(CODE_W) + 1,
  parameter int OUT_W  = 32,
  parameter int ACC_W  = CODE_W + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  input  logic [SIZE_W-1:0]  in_size,
  input  logic               in_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [OUT_W/8-1:0] out_keep,
  output logic               out_last
);

  localparam int FILL_W = $clog2(ACC_W + 1);

  pack_state_t            state;
  logic [ACC_W-1:0]       acc;
  logic [FILL_W-1:0]      fill;
  logic                   alive;
  logic [SIZE_W-1:0]      size_c, lshift;
  logic [ACC_W-1:0]       code_top, code_al;
  logic                   accept, byte_tvalid, byte_tready, byte_fire;
  logic                   src_idle, fin, fin_done, stuff_busy;
  logic [PACK_BYTE_W-1:0] byte_tdata, pad_mask;

  // alive keeps in_ready low through reset and rises on the first cycle after release.
  assign in_ready = alive && (state == RUN) && (fill < FILL_W'(PACK_BYTE_W));
  assign accept   = in_valid && in_ready;

  assign size_c   = (in_size > SIZE_W'(CODE_W)) ? SIZE_W'(CODE_W) : in_size;
  assign lshift   = SIZE_W'(CODE_W) - size_c;
  assign code_top = {in_code, {(ACC_W-CODE_W){1'b0}}};
  assign code_al  = (code_top << lshift) >> fill;

  // A short tail in FLUSH is emitted as one byte padded with 1s.
  assign pad_mask    = (fill < FILL_W'(PACK_BYTE_W)) ? (8'hFF >> fill) : 8'h00;
  assign byte_tdata  = acc[ACC_W-1 -: PACK_BYTE_W] | pad_mask;
  assign byte_tvalid = (fill >= FILL_W'(PACK_BYTE_W)) || (state == FLUSH && fill != '0);
  assign byte_fire   = byte_tvalid && byte_tready;
  assign src_idle    = (state != RUN) && (fill == '0);
  assign fin         = (state == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      acc   <= '0;
      fill  <= '0;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        RUN:     if (accept && in_done) state <= FLUSH;
        FLUSH:   if (fill == '0 && !stuff_busy) state <= LAST;
        LAST:    if (fin_done) state <= RUN;
        default: state <= RUN;
      endcase
      if (accept) begin
        acc  <= acc | code_al;
        fill <= fill + FILL_W'(size_c);
      end else if (byte_fire) begin
        acc  <= acc << PACK_BYTE_W;
        fill <= (fill >= FILL_W'(PACK_BYTE_W)) ? fill - FILL_W'(PACK_BYTE_W) : '0;
      end
    end
  end

  huffman_word_assembler #(
    .OUT_W(OUT_W)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_tdata (byte_tdata),
    .byte_tvalid(byte_tvalid),
    .byte_tready(byte_tready),
    .src_idle   (src_idle),
    .fin        (fin),
    .fin_done   (fin_done),
    .stuff_busy (stuff_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb/tb_huffman_bit_packer.sv - self-checking bench for huffman_bit_packer (OUT_W=32)
// Expectations follow HUFF_PACK_STUFF_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_done;
  logic [35:0] in_code;
  logic [5:0]  in_size;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic stall = 1'b0;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];

  typedef struct {
    int              n;
    logic [3:0][35:0] code;
    logic [3:0][5:0]  size;
    logic [31:0]     data;
    logic [3:0]      keep;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  huffman_bit_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_size  (in_size),
    .in_done  (in_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    if (idx < q_data.size()) begin
      check({tag, "_data"}, 64'(q_data[idx]), 64'(d));
      check({tag, "_keep"}, 64'(q_keep[idx]), 64'(k));
      check({tag, "_last"}, 64'(q_last[idx]), 64'(l));
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_missing: word %0d absent, required 0x%08h", tag, idx, d);
    end
  endtask

  function automatic vec_t mk(input int n,
                              input logic [35:0] c0, input logic [5:0] s0,
                              input logic [35:0] c1, input logic [5:0] s1,
                              input logic [35:0] c2, input logic [5:0] s2,
                              input logic [35:0] c3, input logic [5:0] s3,
                              input logic [31:0] d, input logic [3:0] k);
    vec_t v;
    v.n    = n;
    v.code = {c3, c2, c1, c0};
    v.size = {s3, s2, s1, s0};
    v.data = d;
    v.keep = k;
    return v;
  endfunction

  // Sink side: drives out_ready, collects words, and checks that a stalled word holds still.
  initial begin : monitor
    logic        held;
    logic [31:0] h_data;
    logic [3:0]  h_keep;
    logic        h_last;
    held      = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = !stall;
      if (rst_n && held) begin
        check("hold_data", 64'(out_data), 64'(h_data));
        check("hold_keep", 64'(out_keep), 64'(h_keep));
        check("hold_last", 64'(out_last), 64'(h_last));
      end
      if (rst_n && out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_keep.push_back(out_keep);
        q_last.push_back(out_last);
      end
      held   = rst_n && out_valid && !out_ready;
      h_data = out_data;
      h_keep = out_keep;
      h_last = out_last;
    end
  end

  task automatic send(input logic [35:0] c, input logic [5:0] s, input logic d);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = c;
    in_size  = s;
    in_done  = d;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready 0 after %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (q_data.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_q();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
  endtask

  logic [35:0] c_q[$];
  logic [5:0]  s_q[$];

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [63:0] r;
    logic [7:0]  eb[$];
    bit          bits[$];
    logic [7:0]  by;
    logic [31:0] d;
    logic [3:0]  k;
    int          nw;
    int          sz;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    in_size  = '0;
    in_done  = 1'b0;

`ifdef HUFF_PACK_STUFF_EN
    vecs[1] = mk(2, 36'hFF, 8, 36'h12, 8, 0, 0, 0, 0, 32'hFF001200, 4'b1110);
    vecs[3] = mk(1, 36'h7F, 7, 0, 0, 0, 0, 0, 0, 32'hFF000000, 4'b1100);
    vecs[5] = mk(1, 36'h3FF, 10, 0, 0, 0, 0, 0, 0, 32'hFF00FF00, 4'b1111);
`else
    vecs[1] = mk(2, 36'hFF, 8, 36'h12, 8, 0, 0, 0, 0, 32'hFF120000, 4'b1100);
    vecs[3] = mk(1, 36'h7F, 7, 0, 0, 0, 0, 0, 0, 32'hFF000000, 4'b1000);
    vecs[5] = mk(1, 36'h3FF, 10, 0, 0, 0, 0, 0, 0, 32'hFFFF0000, 4'b1100);
`endif
    vecs[0] = mk(4, 36'h5, 3, 36'h1F, 5, 36'hABCD, 16, 36'h12, 8, 32'hBFABCD12, 4'hF);
    vecs[2] = mk(1, 36'h0, 1, 0, 0, 0, 0, 0, 0, 32'h7F000000, 4'b1000);
    vecs[4] = mk(1, 36'h0, 0, 0, 0, 0, 0, 0, 0, 32'h00000000, 4'b0000);
    vecs[6] = mk(2, 36'h1, 1, 36'h0, 2, 0, 0, 0, 0, 32'h9F000000, 4'b1000);
    vecs[7] = mk(1, 36'hFFFFFFABC, 12, 0, 0, 0, 0, 0, 0, 32'hABCF0000, 4'b1100);
    vecs[8] = mk(3, 36'hA, 4, 36'h7, 0, 36'h5, 4, 0, 0, 32'hA5000000, 4'b1000);

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_keep", 64'(out_keep), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'(1));

    for (int v = 0; v < 9; v++) begin
      clear_q();
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].code[i], vecs[v].size[i], i == vecs[v].n - 1);
      end
      drain(1);
      check($sformatf("vec%0d_nwords", v), 64'(q_data.size()), 64'(1));
      check_word($sformatf("vec%0d", v), 0, vecs[v].data, vecs[v].keep, 1'b1);
    end

    // Oversized code length clamps to 36 bits and spills into a second word.
    clear_q();
    send(36'h123456789, 6'd63, 1'b1);
    drain(2);
    check("clamp_nwords", 64'(q_data.size()), 64'(2));
    check_word("clamp_w0", 0, 32'h12345678, 4'hF, 1'b0);
    check_word("clamp_w1", 1, 32'h9F000000, 4'b1000, 1'b1);

    // Long stream under a sink stall, compared byte-for-byte with a bit-level model.
    clear_q();
    c_q.delete();
    s_q.delete();
    for (int i = 0; i < 40; i++) begin
      r = {$urandom(), $urandom()};
      c_q.push_back((i % 2 == 0) ? 36'hFFFFFFFFF : r[35:0]);
      s_q.push_back(6'($urandom_range(36, 8)));
    end
    fork
      begin
        for (int i = 0; i < 40; i++) send(c_q[i], s_q[i], i == 39);
      end
      begin
        repeat (12) @(negedge clk);
        stall = 1'b1;
        repeat (16) @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'(0));
        stall = 1'b0;
      end
    join

    bits.delete();
    eb.delete();
    for (int i = 0; i < 40; i++) begin
      for (int b = int'(s_q[i]) - 1; b >= 0; b--) bits.push_back(c_q[i][b]);
    end
    while (bits.size() % 8 != 0) bits.push_back(1'b1);
    for (int i = 0; i < bits.size() / 8; i++) begin
      by = '0;
      for (int b = 0; b < 8; b++) by = {by[6:0], bits[8*i+b]};
      eb.push_back(by);
`ifdef HUFF_PACK_STUFF_EN
      if (by == 8'hFF) eb.push_back(8'h00);
`endif
    end
    sz = eb.size();
    nw = (sz + 3) / 4;
    if (nw == 0) nw = 1;
    drain(nw);
    check("bp_nwords", 64'(q_data.size()), 64'(nw));
    for (int w = 0; w < nw; w++) begin
      d = '0;
      k = '0;
      for (int l = 0; l < 4; l++) begin
        if (4*w + l < sz) begin
          d[31-8*l -: 8] = eb[4*w+l];
          k[3-l] = 1'b1;
        end
      end
      check_word($sformatf("bp_w%0d", w), w, d, k, w == nw - 1);
    end

    // Reset in the middle of a code discards it; the next stream starts clean.
    clear_q();
    send(36'hFFFFF, 6'd20, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_data", 64'(out_data), 64'(0));
    check("mid_rst_out_keep", 64'(out_keep), 64'(0));
    check("mid_rst_out_last", 64'(out_last), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", 64'(in_ready), 64'(1));
    clear_q();
    for (int i = 0; i < 4; i++) send(36'hA5, 6'd8, i == 3);
    drain(1);
    check("post_rst_nwords", 64'(q_data.size()), 64'(1));
    check_word("post_rst", 0, 32'hA5A5A5A5, 4'hF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
